clock_set_ctrl: RTL and testbench
=================================

# clock_set_ctrl

Time-setting controller for the digital clock. It debounces the three active-low buttons (mode, up, down) and steps through RUN → SET_H → SET_MI → SET_SE → RUN. In each SET state it pauses timekeeping and enables only the selected counter. It then drives that counter's active-low increase/decrease lines with single-cycle pulses, including hold-to-repeat. It sits between the button pins / 1 Hz tick generator and the hour, minute and second counters, and also supplies the blink flag to the 7-segment display driver.

## Interface
- DB_CYCLES, 500000: consecutive stable cycles before a debounced level changes (10 ms at 50 MHz).
- REPEAT_DELAY, 25000000: cycles a button must be held after the first pulse before auto-repeat starts.
- REPEAT_PERIOD, 5000000: cycles between auto-repeat pulses.
- TIMEOUT_S, 30: `pulse_1s` ticks without any button press before a SET state returns to RUN.
- BLINK_CYCLES, 12500000: cycles per half-period of `blink` in SET states.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- btn_mode, btn_up, btn_down  in  1 each  raw buttons, active-low, asynchronous to `clk`.
- pulse_1s  in  1  one-cycle 1 Hz tick from the prescaler.
- pulse_1s_out  out  1  tick to the seconds counter: `pulse_1s` when in RUN, otherwise 0 (combinational).
- enable_cnt_h, enable_cnt_mi, enable_cnt_se  out  1 each  counter enables.
- increase_h, decrease_h, increase_mi, decrease_mi, increase_se, decrease_se  out  1 each  active-low adjust lines, idle 1.
- mode  out  2  0 = RUN, 1 = SET_H, 2 = SET_MI, 3 = SET_SE.
- blink  out  1  1 = show the selected field, 0 = blank it.

## Operation
- **Input path.** Each button passes through a 2-FF synchronizer, then a stability counter. The debounced level takes the synchronized value after DB_CYCLES consecutive equal samples. A press is a 1→0 transition of the debounced level.
- **FSM transitions.**
  - A mode press advances RUN → SET_H → SET_MI → SET_SE → RUN.
  - In any SET state, when the timeout counter reaches TIMEOUT_S, the state goes to RUN.
  - The timeout counter clears on any press (mode, up or down) and on every state change. It increments on `pulse_1s` only in SET states.
- **Enables.**
  - RUN: all three enables are 1.
  - SET_x: only counter x is enabled; the other two are 0.
- **Adjust pulses.**
  - In a SET state, an up press drives the selected counter's `increase_*` low for exactly one cycle. A down press does the same on `decrease_*`.
  - Up/down activity in RUN is ignored, and no pulse is generated.
- **Auto-repeat.**
  - While the button stays debounced-low, a further pulse is issued REPEAT_DELAY cycles after the first pulse, then every REPEAT_PERIOD cycles after that.
  - Auto-repeat pulses also clear the timeout counter.
- **Priority and spacing.**
  - Up has priority over down. A down press or down-repeat is ignored while up is debounced-low.
  - `increase_*` and `decrease_*` are never low in the same cycle.
  - There are at least 2 idle cycles (line high) between any two pulses.
- **Mode change during a hold.**
  - Repeat timing restarts, and no pulse is issued to the new counter until a fresh press.
  - Any pulse in flight completes on the old counter's line.
- **Blink.**
  - In RUN, `blink` is held at 1.
  - In SET states, `blink` toggles every BLINK_CYCLES.
  - On entering a SET state and on every adjust pulse, `blink` is forced to 1 and its counter is restarted.
- **Widths.** All internal counters are sized with $clog2 of their parameter plus 1. They saturate at their terminal value and never wrap.

## Timing
- **Reset** (synchronous, `rst`=0 at a rising edge). Values take effect at that edge:
  - mode = 0 and all enables = 1.
  - All increase/decrease lines = 1 and blink = 1.
  - Debounced levels = 1 (released); all counters = 0.
  - Reset during a pulse ends it immediately, with the line high after that edge.
- **Press latency.** Let edge 0 be the first rising edge that samples the new raw level.
  - The debounced level changes at edge DB_CYCLES+2.
  - `mode` or the adjust line changes at edge DB_CYCLES+3.
- **Adjust pulse.** The line is low for exactly one clock period, then high.
- **Simultaneous events.**
  - Mode press and up/down press in the same cycle: the mode change wins and no adjust pulse is issued.
  - Timeout and mode press in the same cycle: the mode press wins.
- **`pulse_1s_out`** has zero latency from `pulse_1s`. It is suppressed in the same cycle the FSM leaves RUN (registered mode ≠ 0).

## Test plan
Bench parameters: DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, TIMEOUT_S=3, BLINK_CYCLES=5.

- **Reset:** hold `rst`=0 with buttons bouncing → mode=0, enables=111, all adjust lines 1, blink=1; `pulse_1s_out` follows `pulse_1s`.
- **Mode cycling and debounce:** glitch `btn_mode` low for 3 cycles, then press cleanly 4 times →
  - the glitch has no effect;
  - mode goes 1, 2, 3, 0, each changing 7 edges after the clean edge;
  - enables read 100, 010, 001, 111.
- **Single adjust:** in SET_MI, press up for 10 cycles →
  - exactly one 1-cycle low on `increase_mi`;
  - `increase_h` and `increase_se` stay 1;
  - blink is forced to 1;
  - `pulse_1s_out` stays 0 throughout.
- **Auto-repeat and priority:** in SET_SE, hold up for 60 cycles after the debounced press →
  - `increase_se` pulses at offsets 0, 20, 28, 36, 44, 52;
  - pressing down mid-hold produces no `decrease_se` pulse.
- **Timeout and collision:**
  - In SET_H with no presses, after 3 `pulse_1s` ticks → mode=0 and all enables=1.
  - Repeat the setup, but align a mode press with the 3rd tick → mode advances to 2.
- **Reset mid-pulse and mode during hold:**
  - Assert `rst` in the cycle `increase_mi`=0 → line is 1 after that edge and mode=0.
  - Hold up in SET_H, then press mode → no `increase_mi` pulse until up is released and pressed again.

Source files
------------

// File: rtl/clock_set_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : clock_set_ctrl                                                  |
// | Function : button debounce, RUN/SET mode FSM and counter adjust pulses      |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module clock_set_ctrl #(
    parameter int DB_CYCLES     = 500000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int TIMEOUT_S     = 30,
    parameter int BLINK_CYCLES  = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       pulse_1s,
    output logic       pulse_1s_out,
    output logic       enable_cnt_h,
    output logic       enable_cnt_mi,
    output logic       enable_cnt_se,
    output logic       increase_h,
    output logic       decrease_h,
    output logic       increase_mi,
    output logic       decrease_mi,
    output logic       increase_se,
    output logic       decrease_se,
    output logic [1:0] mode,
    output logic       blink
);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_SET_H  = 2'd1;
    localparam logic [1:0] S_SET_MI = 2'd2;
    localparam logic [1:0] S_SET_SE = 2'd3;

    localparam int B_MODE = 0;
    localparam int B_UP   = 1;
    localparam int B_DN   = 2;

    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DB_W  = $clog2(DB_CYCLES) + 1;
    localparam int REP_W = $clog2(REP_MAX) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_S) + 1;
    localparam int BL_W  = $clog2(BLINK_CYCLES) + 1;

    localparam logic [DB_W-1:0]  C_DB_MAX  = DB_W'(DB_CYCLES);
    localparam logic [REP_W-1:0] C_RD_M1   = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] C_RP_M1   = REP_W'(REPEAT_PERIOD - 1);
    localparam logic [REP_W-1:0] C_REP_SAT = REP_W'(REP_MAX);
    localparam logic [TO_W-1:0]  C_TO_MAX  = TO_W'(TIMEOUT_S);
    localparam logic [BL_W-1:0]  C_BL_M1   = BL_W'(BLINK_CYCLES - 1);

    logic [2:0]       w_btn_raw;
    logic [2:0]       r_sync1, r_sync2, r_db, r_db_d;
    logic [DB_W-1:0]  r_db_cnt [0:2];
    logic [2:0]       w_press;
    logic [1:0]       r_state, w_state_nxt;
    logic             w_in_set, w_state_chg, w_adj_ok;
    logic             r_rep_act, r_rep_dir, r_rep_long;
    logic [REP_W-1:0] r_rep_cnt, w_rep_tgt;
    logic             w_rep_hold, w_rep_fire;
    logic             r_pend_up, r_pend_dn;
    logic             w_req_up, w_req_dn, w_issue_up, w_issue_dn, w_issue;
    logic [1:0]       r_gap;
    logic [TO_W-1:0]  r_to_cnt;
    logic [BL_W-1:0]  r_bl_cnt;
    logic             r_blink;
    logic             r_inc_h, r_dec_h, r_inc_mi, r_dec_mi, r_inc_se, r_dec_se;

    assign w_btn_raw = {btn_down, btn_up, btn_mode};
    assign w_press   = r_db_d & ~r_db;

    // 2-FF synchronizer followed by a stability counter per button
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_db    <= '1;
            r_db_d  <= '1;
            for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == C_DB_MAX) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_RUN;
        else      r_state <= w_state_nxt;
    end

    // Mode press outranks timeout; SET_SE + 1 wraps back to RUN
    always_comb begin
        w_state_nxt   = r_state;
        enable_cnt_h  = 1'b1;
        enable_cnt_mi = 1'b1;
        enable_cnt_se = 1'b1;
        if (w_press[B_MODE])
            w_state_nxt = r_state + 2'd1;
        else if (r_state != S_RUN && r_to_cnt == C_TO_MAX)
            w_state_nxt = S_RUN;
        case (r_state)
            S_SET_H:  begin enable_cnt_mi = 1'b0; enable_cnt_se = 1'b0; end
            S_SET_MI: begin enable_cnt_h  = 1'b0; enable_cnt_se = 1'b0; end
            S_SET_SE: begin enable_cnt_h  = 1'b0; enable_cnt_mi = 1'b0; end
            default:  ;
        endcase
    end

    assign w_in_set    = (r_state != S_RUN);
    assign w_state_chg = (w_state_nxt != r_state);
    assign w_adj_ok    = w_in_set & ~w_state_chg;

    assign w_rep_tgt  = r_rep_long ? C_RD_M1 : C_RP_M1;
    assign w_rep_hold = r_rep_act & (r_rep_dir ? ~r_db[B_DN] : ~r_db[B_UP]);
    assign w_rep_fire = w_rep_hold & (r_rep_cnt >= w_rep_tgt);

    // Requests blocked by the inter-pulse gap stay pending until the gap ends
    assign w_req_up   = w_adj_ok & (w_press[B_UP] | r_pend_up | (w_rep_fire & ~r_rep_dir));
    assign w_req_dn   = w_adj_ok & r_db[B_UP] & (w_press[B_DN] | r_pend_dn | (w_rep_fire & r_rep_dir));
    assign w_issue_up = w_req_up & (r_gap == 2'd0);
    assign w_issue_dn = w_req_dn & ~w_req_up & (r_gap == 2'd0);
    assign w_issue    = w_issue_up | w_issue_dn;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pend_up <= 1'b0;
            r_pend_dn <= 1'b0;
            r_gap     <= 2'd0;
        end else begin
            r_pend_up <= w_req_up & ~w_issue_up;
            r_pend_dn <= w_req_dn & ~w_issue_dn;
            if (w_issue)             r_gap <= 2'd2;
            else if (r_gap != 2'd0)  r_gap <= r_gap - 2'd1;
        end
    end

    // A pulse issued while already repeating in the same direction uses the short period
    always_ff @(posedge clk) begin
        if (!rst || w_state_chg) begin
            r_rep_act  <= 1'b0;
            r_rep_dir  <= 1'b0;
            r_rep_long <= 1'b1;
            r_rep_cnt  <= '0;
        end else if (w_issue) begin
            r_rep_act  <= 1'b1;
            r_rep_dir  <= w_issue_dn;
            r_rep_long <= ~(r_rep_act & (r_rep_dir == w_issue_dn));
            r_rep_cnt  <= '0;
        end else if (!w_rep_hold) begin
            r_rep_act  <= 1'b0;
            r_rep_cnt  <= '0;
        end else if (r_rep_cnt != C_REP_SAT) begin
            r_rep_cnt  <= r_rep_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || w_state_chg || (|w_press) || w_issue)
            r_to_cnt <= '0;
        else if (w_in_set && pulse_1s && r_to_cnt != C_TO_MAX)
            r_to_cnt <= r_to_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst || w_state_nxt == S_RUN || w_state_chg || w_issue) begin
            r_blink  <= 1'b1;
            r_bl_cnt <= '0;
        end else if (r_bl_cnt == C_BL_M1) begin
            r_blink  <= ~r_blink;
            r_bl_cnt <= '0;
        end else begin
            r_bl_cnt <= r_bl_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_inc_h  <= 1'b1; r_dec_h  <= 1'b1;
            r_inc_mi <= 1'b1; r_dec_mi <= 1'b1;
            r_inc_se <= 1'b1; r_dec_se <= 1'b1;
        end else begin
            r_inc_h  <= ~(w_issue_up && r_state == S_SET_H);
            r_dec_h  <= ~(w_issue_dn && r_state == S_SET_H);
            r_inc_mi <= ~(w_issue_up && r_state == S_SET_MI);
            r_dec_mi <= ~(w_issue_dn && r_state == S_SET_MI);
            r_inc_se <= ~(w_issue_up && r_state == S_SET_SE);
            r_dec_se <= ~(w_issue_dn && r_state == S_SET_SE);
        end
    end

    assign pulse_1s_out = pulse_1s & (r_state == S_RUN);
    assign mode         = r_state;
    assign blink        = r_blink;
    assign increase_h   = r_inc_h;
    assign decrease_h   = r_dec_h;
    assign increase_mi  = r_inc_mi;
    assign decrease_mi  = r_dec_mi;
    assign increase_se  = r_inc_se;
    assign decrease_se  = r_dec_se;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_clock_set_ctrl                                               |
// | Function : directed self-checking bench for clock_set_ctrl                  |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module tb_clock_set_ctrl;

    localparam int BM = 0;
    localparam int BU = 1;
    localparam int BD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b1, btn_up = 1'b1, btn_down = 1'b1, pulse_1s = 1'b0;
    logic       pulse_1s_out;
    logic       enable_cnt_h, enable_cnt_mi, enable_cnt_se;
    logic       increase_h, decrease_h, increase_mi, decrease_mi, increase_se, decrease_se;
    logic [1:0] mode;
    logic       blink;

    int n_cmp  = 0;
    int n_fail = 0;

    clock_set_ctrl #(
        .DB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8), .TIMEOUT_S(3), .BLINK_CYCLES(5)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .pulse_1s(pulse_1s), .pulse_1s_out(pulse_1s_out),
        .enable_cnt_h(enable_cnt_h), .enable_cnt_mi(enable_cnt_mi), .enable_cnt_se(enable_cnt_se),
        .increase_h(increase_h), .decrease_h(decrease_h),
        .increase_mi(increase_mi), .decrease_mi(decrease_mi),
        .increase_se(increase_se), .decrease_se(decrease_se),
        .mode(mode), .blink(blink)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ens();
        return {enable_cnt_h, enable_cnt_mi, enable_cnt_se};
    endfunction

    function automatic logic [5:0] lines();
        return {increase_h, decrease_h, increase_mi, decrease_mi, increase_se, decrease_se};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            BM:      btn_mode = v;
            BU:      btn_up   = v;
            default: btn_down = v;
        endcase
    endtask

    task automatic press_btn(input int b, input int low_cyc, input int high_cyc);
        set_btn(b, 1'b0);
        cyc(low_cyc);
        set_btn(b, 1'b1);
        cyc(high_cyc);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            btn_mode = i[0]; btn_up = ~i[0]; btn_down = i[1];
            cyc(1);
        end
        n_cmp++; if (mode !== 2'd0) begin n_fail++; $display("FAIL reset_mode: got %0d want 0", mode); end
        n_cmp++; if (ens() !== 3'b111) begin n_fail++; $display("FAIL reset_enables: got %b want 111", ens()); end
        n_cmp++; if (lines() !== 6'b111111) begin n_fail++; $display("FAIL reset_lines: got %b want 111111", lines()); end
        n_cmp++; if (blink !== 1'b1) begin n_fail++; $display("FAIL reset_blink: got %b want 1", blink); end
        pulse_1s = 1'b1; #1;
        n_cmp++; if (pulse_1s_out !== 1'b1) begin n_fail++; $display("FAIL reset_p1s_hi: got %b want 1", pulse_1s_out); end
        pulse_1s = 1'b0; #1;
        n_cmp++; if (pulse_1s_out !== 1'b0) begin n_fail++; $display("FAIL reset_p1s_lo: got %b want 0", pulse_1s_out); end
        btn_mode = 1'b1; btn_up = 1'b1; btn_down = 1'b1;
        cyc(1);
        rst = 1'b1;
        cyc(12);
    endtask

    task automatic test_mode_cycle();
        logic [1:0] exp_mode [4];
        logic [2:0] exp_en   [4];
        logic [1:0] prev;
        exp_mode = '{2'd1, 2'd2, 2'd3, 2'd0};
        exp_en   = '{3'b100, 3'b010, 3'b001, 3'b111};
        btn_mode = 1'b0; cyc(3); btn_mode = 1'b1; cyc(12);
        n_cmp++; if (mode !== 2'd0) begin n_fail++; $display("FAIL glitch_mode: got %0d want 0", mode); end
        prev = 2'd0;
        for (int k = 0; k < 4; k++) begin
            btn_mode = 1'b0;
            cyc(7);
            n_cmp++; if (mode !== prev) begin n_fail++; $display("FAIL mode_early_%0d: got %0d want %0d", k, mode, prev); end
            cyc(1);
            n_cmp++; if (mode !== exp_mode[k]) begin n_fail++; $display("FAIL mode_step_%0d: got %0d want %0d", k, mode, exp_mode[k]); end
            n_cmp++; if (ens() !== exp_en[k]) begin n_fail++; $display("FAIL enables_%0d: got %b want %b", k, ens(), exp_en[k]); end
            if (k == 0) begin
                cyc(4);
                n_cmp++; if (blink !== 1'b1) begin n_fail++; $display("FAIL blink_hold: got %b want 1", blink); end
                cyc(1);
                n_cmp++; if (blink !== 1'b0) begin n_fail++; $display("FAIL blink_toggle: got %b want 0", blink); end
            end
            prev = exp_mode[k];
            btn_mode = 1'b1;
            cyc(10);
        end
        n_cmp++; if (blink !== 1'b1) begin n_fail++; $display("FAIL blink_run: got %b want 1", blink); end
    endtask

    task automatic test_single_adjust();
        int n_low, low_at, n_other, n_p1s;
        logic bl_at_pulse;
        press_btn(BM, 8, 10);
        press_btn(BM, 8, 10);
        n_cmp++; if (mode !== 2'd2) begin n_fail++; $display("FAIL adj_mode: got %0d want 2", mode); end
        n_low = 0; low_at = -1; n_other = 0; n_p1s = 0; bl_at_pulse = 1'b0;
        btn_up = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            cyc(1);
            if (increase_mi === 1'b0) begin n_low++; low_at = i; bl_at_pulse = blink; end
            if ({increase_h, decrease_h, decrease_mi, increase_se, decrease_se} !== 5'b11111) n_other++;
            if (pulse_1s_out !== 1'b0) n_p1s++;
            pulse_1s = (i == 2 || i == 12);
            if (i == 10) btn_up = 1'b1;
        end
        pulse_1s = 1'b0;
        n_cmp++; if (n_low !== 1) begin n_fail++; $display("FAIL adj_count: got %0d want 1", n_low); end
        n_cmp++; if (low_at !== 8) begin n_fail++; $display("FAIL adj_latency: got %0d want 8", low_at); end
        n_cmp++; if (n_other !== 0) begin n_fail++; $display("FAIL adj_other_lines: got %0d want 0", n_other); end
        n_cmp++; if (bl_at_pulse !== 1'b1) begin n_fail++; $display("FAIL adj_blink: got %b want 1", bl_at_pulse); end
        n_cmp++; if (n_p1s !== 0) begin n_fail++; $display("FAIL adj_p1s_out: got %0d want 0", n_p1s); end
        cyc(8);
    endtask

    task automatic test_auto_repeat();
        int offs[$];
        int exp_offs [6];
        int n_dec, n_other, got;
        exp_offs = '{0, 20, 28, 36, 44, 52};
        press_btn(BM, 8, 10);
        n_cmp++; if (mode !== 2'd3) begin n_fail++; $display("FAIL rep_mode: got %0d want 3", mode); end
        n_dec = 0; n_other = 0;
        btn_up = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            cyc(1);
            if (increase_se === 1'b0) offs.push_back(i - 8);
            if (decrease_se === 1'b0) n_dec++;
            if ({increase_h, decrease_h, increase_mi, decrease_mi} !== 4'b1111) n_other++;
            if (i == 18) btn_down = 1'b0;
            if (i == 38) btn_down = 1'b1;
            if (i == 58) btn_up = 1'b1;
        end
        n_cmp++; if (offs.size() !== 6) begin n_fail++; $display("FAIL rep_count: got %0d want 6", offs.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < offs.size()) ? offs[i] : -1;
            n_cmp++; if (got !== exp_offs[i]) begin n_fail++; $display("FAIL rep_offset_%0d: got %0d want %0d", i, got, exp_offs[i]); end
        end
        n_cmp++; if (n_dec !== 0) begin n_fail++; $display("FAIL rep_down_ignored: got %0d want 0", n_dec); end
        n_cmp++; if (n_other !== 0) begin n_fail++; $display("FAIL rep_other_lines: got %0d want 0", n_other); end
        cyc(8);
    endtask

    task automatic test_timeout();
        press_btn(BM, 8, 10);
        press_btn(BM, 8, 10);
        n_cmp++; if (mode !== 2'd1) begin n_fail++; $display("FAIL to_enter: got %0d want 1", mode); end
        for (int t = 0; t < 3; t++) begin
            pulse_1s = 1'b1; cyc(1); pulse_1s = 1'b0; cyc(3);
            if (t == 1) begin
                n_cmp++; if (mode !== 2'd1) begin n_fail++; $display("FAIL to_two_ticks: got %0d want 1", mode); end
            end
        end
        n_cmp++; if (mode !== 2'd0) begin n_fail++; $display("FAIL to_expire: got %0d want 0", mode); end
        n_cmp++; if (ens() !== 3'b111) begin n_fail++; $display("FAIL to_enables: got %b want 111", ens()); end
        press_btn(BM, 8, 10);
        for (int t = 0; t < 2; t++) begin
            pulse_1s = 1'b1; cyc(1); pulse_1s = 1'b0; cyc(3);
        end
        btn_mode = 1'b0;
        cyc(7);
        pulse_1s = 1'b1; cyc(1); pulse_1s = 1'b0;
        n_cmp++; if (mode !== 2'd2) begin n_fail++; $display("FAIL collide_step: got %0d want 2", mode); end
        cyc(4); btn_mode = 1'b1; cyc(10);
        n_cmp++; if (mode !== 2'd2) begin n_fail++; $display("FAIL collide_hold: got %0d want 2", mode); end
    endtask

    task automatic test_reset_mid_pulse();
        btn_up = 1'b0;
        cyc(8);
        n_cmp++; if (increase_mi !== 1'b0) begin n_fail++; $display("FAIL rmp_pulse: got %b want 0", increase_mi); end
        rst = 1'b0;
        cyc(1);
        n_cmp++; if (increase_mi !== 1'b1) begin n_fail++; $display("FAIL rmp_line: got %b want 1", increase_mi); end
        n_cmp++; if (mode !== 2'd0) begin n_fail++; $display("FAIL rmp_mode: got %0d want 0", mode); end
        rst = 1'b1; btn_up = 1'b1;
        cyc(12);
    endtask

    task automatic test_mode_during_hold();
        int n_h, n_mi, n_mi2;
        press_btn(BM, 8, 10);
        n_h = 0; n_mi = 0; n_mi2 = 0;
        btn_up = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            cyc(1);
            if (increase_h === 1'b0) n_h++;
            if (increase_mi === 1'b0) n_mi++;
            if (i == 10) btn_mode = 1'b0;
            if (i == 20) btn_mode = 1'b1;
        end
        n_cmp++; if (mode !== 2'd2) begin n_fail++; $display("FAIL hold_mode: got %0d want 2", mode); end
        n_cmp++; if (n_h !== 1) begin n_fail++; $display("FAIL hold_old_line: got %0d want 1", n_h); end
        n_cmp++; if (n_mi !== 0) begin n_fail++; $display("FAIL hold_new_line: got %0d want 0", n_mi); end
        btn_up = 1'b1;
        cyc(12);
        btn_up = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            cyc(1);
            if (increase_mi === 1'b0) n_mi2++;
        end
        n_cmp++; if (n_mi2 !== 1) begin n_fail++; $display("FAIL hold_fresh_press: got %0d want 1", n_mi2); end
        btn_up = 1'b1;
        cyc(10);
    endtask

    initial begin
        test_reset();
        test_mode_cycle();
        test_single_adjust();
        test_auto_repeat();
        test_timeout();
        test_reset_mid_pulse();
        test_mode_during_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
